pipo_write_arbiter: RTL and testbench

// - Round-robin arbiter that shares one WIDTH-bit PIPO register between NUM_REQ writers.
// - Sits directly in front of the register and drives its load and in ports.
// - Each requester presents a write request plus data and gets a one-cycle grant pulse

---
 rtl/pipo_write_arbiter.sv | 121 ++++++++++++
 tb/tb_pipo_write_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipo_write_arbiter.sv
// rtl/pipo_write_arbiter.sv - round-robin write arbiter in front of a shared PIPO register
//
// Purpose:
//   Shares one WIDTH-bit PIPO register between NUM_REQ writers. An IDLE -> LOAD -> HOLD
//   sequence picks one requester at a time in round-robin order. The sequence latches
//   that requester's data and pulses its grant together with the register load strobe.
//   It then keeps the register stable for HOLD_CYCLES cycles.
//
// Ports:
//   clk       in   1                rising-edge clock
//   rst       in   1                asynchronous active-high reset
//   req       in   NUM_REQ          per-requester write request (level)
//   wdata     in   NUM_REQ*WIDTH    flattened write data, requester i at [i*WIDTH +: WIDTH]
//   gnt       out  NUM_REQ          one-hot grant pulse, coincident with reg_load
//   reg_load  out  1                load strobe to the PIPO register
//   reg_in    out  WIDTH            data to the PIPO register
//   busy      out  1                high while in LOAD or HOLD
//   last_src  out  IW               index of the most recent writer
module pipo_write_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 1,
  localparam int IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     reg_load,
  output logic [WIDTH-1:0]         reg_in,
  output logic                     busy,
  output logic [IW-1:0]            last_src
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD} state_t;

  state_t               state, state_nxt;
  logic [IW-1:0]        rr_ptr;
  logic [3:0]           hold_cnt;
  logic                 found;
  logic [IW-1:0]        win;
  logic [WIDTH-1:0]     win_data;
  logic                 hold_done;
  logic [NUM_REQ-1:0]   gnt_nxt;
  logic                 load_nxt;
  logic                 busy_nxt;
  int                   best_d;
  int                   d;

  // Winner is the set request with the smallest forward distance from rr_ptr.
  always_comb begin
    found    = |req;
    win      = '0;
    win_data = '0;
    best_d   = NUM_REQ;
    d        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i]) begin
        d = (i + NUM_REQ - int'(rr_ptr)) % NUM_REQ;
        if (d < best_d) begin
          best_d = d;
          win    = IW'(i);
        end
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == IW'(i)) win_data = wdata[i*WIDTH +: WIDTH];
    end
  end

  assign hold_done = (hold_cnt == 4'(HOLD_CYCLES - 1));

  // State register and the datapath registers that follow it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      reg_load <= 1'b0;
      reg_in   <= '0;
      busy     <= 1'b0;
      last_src <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      reg_load <= load_nxt;
      busy     <= busy_nxt;
      hold_cnt <= (state == S_HOLD) ? hold_cnt + 4'd1 : 4'd0;
      // Data and source are captured at the arbitration edge; later wdata changes are ignored.
      if (state == S_IDLE && found) begin
        reg_in   <= win_data;
        last_src <= win;
      end
      if (state == S_LOAD) begin
        rr_ptr <= (last_src == IW'(NUM_REQ - 1)) ? '0 : last_src + 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (found) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = (HOLD_CYCLES > 0) ? S_HOLD : S_IDLE;
      S_HOLD:  if (hold_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    gnt_nxt  = '0;
    load_nxt = (state_nxt == S_LOAD);
    busy_nxt = (state_nxt != S_IDLE);
    if (state == S_IDLE && found) gnt_nxt = NUM_REQ'(1) << win;
  end

endmodule

// File: tb/tb_pipo_write_arbiter.sv
// tb/tb_pipo_write_arbiter.sv - self-checking bench for pipo_write_arbiter
module tb_pipo_write_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] wdata;
  logic [3:0]  gnt;
  logic        reg_load;
  logic [3:0]  reg_in;
  logic        busy;
  logic [1:0]  last_src;

  logic [3:0]  req_z;
  logic [15:0] wdata_z;
  logic [3:0]  gnt_z;
  logic        load_z;
  logic [3:0]  in_z;
  logic        busy_z;
  logic [1:0]  src_z;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int grant_cnt = 0;
  int g_cyc[$];
  int exp_src[$];
  logic [3:0] exp_dat[$];

  pipo_write_arbiter #(.NUM_REQ(4), .WIDTH(4), .HOLD_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata), .gnt(gnt),
    .reg_load(reg_load), .reg_in(reg_in), .busy(busy), .last_src(last_src)
  );

  pipo_write_arbiter #(.NUM_REQ(4), .WIDTH(4), .HOLD_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req_z), .wdata(wdata_z), .gnt(gnt_z),
    .reg_load(load_z), .reg_in(in_z), .busy(busy_z), .last_src(src_z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard side: every load must match the next expected (source, data).
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ((gnt != 4'b0) !== reg_load) begin
        errors++;
        $display("FAIL gnt_vs_load: gnt=%b reg_load=%b", gnt, reg_load);
      end
      if (reg_load) begin
        grant_cnt++;
        g_cyc.push_back(cyc);
        checks++;
        if (exp_src.size() == 0) begin
          errors++;
          $display("FAIL unexpected_load: gnt=%b reg_in=%h required none", gnt, reg_in);
        end else begin
          automatic int s = exp_src.pop_front();
          automatic logic [3:0] dv = exp_dat.pop_front();
          if (gnt !== (4'b1 << s) || reg_in !== dv || last_src !== 2'(s)) begin
            errors++;
            $display("FAIL sb_load: gnt=%b reg_in=%h last_src=%0d required gnt=%b reg_in=%h last_src=%0d",
                     gnt, reg_in, last_src, 4'b1 << s, dv, s);
          end
        end
      end
    end
  end

  task automatic wait_idle(output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 50 && !ok) begin
      @(negedge clk); #1;
      n++;
      if (!busy) ok = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_grants(input int target, output bit ok);
    int n = 0;
    while (grant_cnt < target && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    ok = (grant_cnt >= target);
  endtask

  task automatic test_reset;
    @(negedge clk); #1;
    checks++;
    if (gnt !== 4'b0 || reg_load !== 1'b0 || reg_in !== 4'b0 || busy !== 1'b0 || last_src !== 2'b0 ||
        gnt_z !== 4'b0 || load_z !== 1'b0 || busy_z !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: gnt=%b load=%b in=%h busy=%b src=%0d required all zero",
               gnt, reg_load, reg_in, busy, last_src);
    end
    rst = 1'b0;
  endtask

  task automatic test_rotate;
    bit ok;
    int base;
    wait_idle(ok);
    base = grant_cnt;
    g_cyc.delete();
    wdata = {4'd4, 4'd3, 4'd2, 4'd1};
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_src.push_back(i % 4);
      exp_dat.push_back(4'(i % 4 + 1));
    end
    wait_grants(base + 5, ok);
    req = 4'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rotate_timeout: grants=%0d required %0d", grant_cnt - base, 5);
    end
    for (int i = 1; i < g_cyc.size(); i++) begin
      checks++;
      if (g_cyc[i] - g_cyc[i-1] != 3) begin
        errors++;
        $display("FAIL rotate_spacing: gap=%0d required 3", g_cyc[i] - g_cyc[i-1]);
      end
    end
  endtask

  task automatic test_single;
    bit ok;
    int n = 0;
    int busy_cnt = 0;
    wait_idle(ok);
    wdata = 16'h0b00;
    req = 4'b0100;
    exp_src.push_back(2);
    exp_dat.push_back(4'b1011);
    while (!reg_load && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    req = 4'b0;
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL single_latency: negedges=%0d required 2", n);
    end
    while (busy && busy_cnt < 10) begin
      busy_cnt++;
      if (busy_cnt == 2) begin
        checks++;
        if (reg_in !== 4'b1011 || last_src !== 2'd2 || reg_load !== 1'b0) begin
          errors++;
          $display("FAIL single_hold: reg_in=%h last_src=%0d load=%b required b 2 0", reg_in, last_src, reg_load);
        end
      end
      @(negedge clk); #1;
    end
    checks++;
    if (busy_cnt !== 2) begin
      errors++;
      $display("FAIL single_busy: cycles=%0d required 2", busy_cnt);
    end
  endtask

  task automatic test_priority;
    bit ok;
    int base;
    wait_idle(ok);
    base = grant_cnt;
    wdata = 16'hc007;
    req = 4'b1001;
    exp_src.push_back(3); exp_dat.push_back(4'hc);
    exp_src.push_back(0); exp_dat.push_back(4'h7);
    wait_grants(base + 2, ok);
    req = 4'b0;
    checks++;
    if (!ok || exp_src.size() != 0) begin
      errors++;
      $display("FAIL priority: grants=%0d pending=%0d required 2 0", grant_cnt - base, exp_src.size());
    end
  endtask

  task automatic test_pulse;
    bit ok;
    int base;
    wait_idle(ok);
    base = grant_cnt;
    wdata = 16'h000e;
    req = 4'b0001;
    exp_src.push_back(0); exp_dat.push_back(4'he);
    @(posedge clk); #1;
    req = 4'b0;
    wdata = 16'h0000;
    wait_grants(base + 1, ok);
    @(negedge clk); #1;
    checks++;
    if (!ok || reg_in !== 4'he) begin
      errors++;
      $display("FAIL pulse: ok=%0d reg_in=%h required 1 e", ok, reg_in);
    end
  endtask

  task automatic test_reset_in_load;
    bit ok;
    int base;
    wait_idle(ok);
    base = grant_cnt;
    wdata = 16'h0050;
    req = 4'b0010;
    exp_src.push_back(1); exp_dat.push_back(4'h5);
    wait_grants(base + 1, ok);
    #1 rst = 1'b1;
    #1;
    req = 4'b0;
    checks++;
    if (!ok || reg_load !== 1'b0 || gnt !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_load: ok=%0d load=%b gnt=%b busy=%b required 1 0 0000 0", ok, reg_load, gnt, busy);
    end
    @(negedge clk); #2;
    rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || reg_in !== 4'b0 || last_src !== 2'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b reg_in=%h last_src=%0d required 0 0 0", busy, reg_in, last_src);
    end
    // rr_ptr was 1 before the reset; a cleared pointer must pick requester 0 first.
    @(posedge clk); #1;
    base = grant_cnt;
    wdata = 16'h006a;
    req = 4'b0011;
    exp_src.push_back(0); exp_dat.push_back(4'ha);
    wait_grants(base + 1, ok);
    req = 4'b0;
    wait_idle(ok);
    checks++;
    if (exp_src.size() != 0) begin
      errors++;
      $display("FAIL reset_rr_ptr: pending=%0d required 0", exp_src.size());
    end
  endtask

  task automatic test_hold_zero;
    int loads = 0;
    int last_c = -1;
    logic prev = 1'b0;
    @(posedge clk); #1;
    wdata_z = 16'h0090;
    req_z = 4'b0010;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      checks++;
      if ((gnt_z != 4'b0) !== load_z || (load_z && prev)) begin
        errors++;
        $display("FAIL hold0_strobe: gnt=%b load=%b prev_load=%b", gnt_z, load_z, prev);
      end
      if (load_z) begin
        loads++;
        checks++;
        if (gnt_z !== 4'b0010 || in_z !== 4'h9 || (last_c >= 0 && cyc - last_c != 2)) begin
          errors++;
          $display("FAIL hold0_grant: gnt=%b in=%h gap=%0d required 0010 9 2", gnt_z, in_z, cyc - last_c);
        end
        last_c = cyc;
      end
      prev = load_z;
    end
    req_z = 4'b0;
    checks++;
    if (loads !== 6) begin
      errors++;
      $display("FAIL hold0_count: loads=%0d required 6", loads);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0;
    wdata = 16'h0;
    req_z = 4'b0;
    wdata_z = 16'h0;
    test_reset();
    test_rotate();
    test_single();
    test_priority();
    test_pulse();
    test_reset_in_load();
    test_hold_zero();
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
